// File: rtl/tmr_seq_pkg.sv
// Shared types and Timer register map for the timer config sequencer.
// Optional bus timeout is enabled by defining TMR_SEQ_TIMEOUT_EN.
package tmr_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_RUNW,
    S_MON,
    S_RDISR,
    S_CLR,
    S_HOLD,
    S_STPW
  } state_t;

  localparam logic [31:0] TRS_OFF = 32'h0000_0010;
  localparam logic [31:0] ISR_OFF = 32'h0000_0014;
  localparam logic [31:0] ISC_OFF = 32'h0000_0018;

  localparam logic [31:0] TRS_RUN  = 32'd1;
  localparam logic [31:0] TRS_STOP = 32'd2;

  function automatic logic [31:0] lowest_set(
    input logic [31:0] v
  );
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/tmr_bus_mst.sv
// Single-transfer req/gnt/rvalid bus engine for the timer sequencer.
// TMR_SEQ_TIMEOUT_EN adds a per-transfer wait timeout.
module tmr_bus_mst
  import tmr_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef TMR_SEQ_TIMEOUT_EN
  ,
  parameter int TO_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              go_we,
  input  logic [ADDR_W-1:0] go_addr,
  input  logic [DATA_W-1:0] go_wdata,
  output logic              done,
  output logic              to_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              req,
  output logic              we,
  output logic [3:0]        be,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              gnt,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  logic rd_wait;
  logic rd_phase;
  logic xfer_busy;

  assign xfer_busy = req | rd_wait;
  assign rd_phase  = (req & gnt & ~we) | rd_wait;
  assign done      = (req & gnt & we) | (rd_phase & rvalid);
  assign rd_data   = bus_rdata;

`ifdef TMR_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] cnt;

  assign to_err = xfer_busy & ~done &
                  (cnt == TO_W'(2 ** TO_W - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (go && !xfer_busy) begin
      cnt <= '0;
    end else if (xfer_busy && !done) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign to_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req     <= 1'b0;
      we      <= 1'b0;
      be      <= 4'b0;
      addr    <= '0;
      wdata   <= '0;
      rd_wait <= 1'b0;
    end else if (to_err) begin
      req     <= 1'b0;
      we      <= 1'b0;
      be      <= 4'b0;
      addr    <= '0;
      wdata   <= '0;
      rd_wait <= 1'b0;
    end else if (req && gnt) begin
      req     <= 1'b0;
      we      <= 1'b0;
      be      <= 4'b0;
      addr    <= '0;
      wdata   <= '0;
      rd_wait <= ~we & ~rvalid;
    end else if (rd_wait && rvalid) begin
      rd_wait <= 1'b0;
    end else if (go && !xfer_busy) begin
      req   <= 1'b1;
      we    <= go_we;
      be    <= 4'b1111;
      addr  <= go_addr;
      wdata <= go_we ? go_wdata : '0;
    end
  end

endmodule

// File: rtl/tmr_cfg_seq.sv
// Timer bring-up and IRQ service sequencer (bus master).
// Define TMR_SEQ_TIMEOUT_EN for the bus timeout and sticky err flag.
module tmr_cfg_seq
  import tmr_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
`ifdef TMR_SEQ_TIMEOUT_EN
  ,
  parameter int TO_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_wdata,
  input  logic              tbl_last,
  input  logic              tmr_int,
  output logic              req,
  output logic              we,
  output logic [3:0]        be,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              gnt,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              running,
  output logic              isr_vld,
  output logic [DATA_W-1:0] isr_val,
  output logic              err
);

  state_t            state;
  logic              issued;
  logic              stop_q;
  logic              stop_pend;
  logic              hold_cnt;
  logic [DATA_W-1:0] mask;
  logic              xfer_st;
  logic              skip;
  logic              go;
  logic              go_we;
  logic [ADDR_W-1:0] go_addr;
  logic [DATA_W-1:0] go_wdata;
  logic              done;
  logic              to_err;
  logic [DATA_W-1:0] rd_data;

  assign stop_pend = (stop_q | stop) & (state != S_IDLE);
  assign xfer_st   = (state == S_CFG) | (state == S_RUNW) |
                     (state == S_RDISR) | (state == S_CLR);
  // a stop that lands before a transfer launches skips it entirely
  assign skip      = xfer_st & ~issued & stop_pend;

  assign busy    = (state != S_IDLE);
  assign running = (state == S_MON) | (state == S_RDISR) |
                   (state == S_CLR) | (state == S_HOLD);

  always_comb begin
    go_we    = 1'b1;
    go_addr  = '0;
    go_wdata = '0;
    unique case (state)
      S_CFG: begin
        go_addr  = tbl_addr;
        go_wdata = tbl_wdata;
      end
      S_RUNW: begin
        go_addr  = ADDR_W'(TRS_OFF);
        go_wdata = DATA_W'(TRS_RUN);
      end
      S_MON, S_RDISR: begin
        go_we   = 1'b0;
        go_addr = ADDR_W'(ISR_OFF);
      end
      S_CLR: begin
        go_addr  = ADDR_W'(ISC_OFF);
        go_wdata = mask;
      end
      S_STPW: begin
        go_addr  = ADDR_W'(TRS_OFF);
        go_wdata = DATA_W'(TRS_STOP);
      end
      default: ;
    endcase
    // MON launches the ISR read directly for one-cycle IRQ latency
    go = ((xfer_st | (state == S_STPW)) & ~issued & ~skip) |
         ((state == S_MON) & tmr_int & ~stop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      issued   <= 1'b0;
      stop_q   <= 1'b0;
      hold_cnt <= 1'b0;
      mask     <= '0;
      tbl_idx  <= '0;
      isr_vld  <= 1'b0;
      isr_val  <= '0;
    end else begin
      isr_vld <= 1'b0;
      stop_q  <= stop_pend & (state != S_STPW);
      if (done) issued <= 1'b0;
      else if (go) issued <= 1'b1;
      if (to_err) begin
        state  <= S_IDLE;
        issued <= 1'b0;
        stop_q <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state   <= S_CFG;
              tbl_idx <= '0;
            end
          end
          S_CFG: begin
            if (done) begin
              if (stop_pend) state <= S_STPW;
              else if (tbl_last || &tbl_idx) state <= S_RUNW;
              else tbl_idx <= tbl_idx + 1'b1;
            end else if (skip) begin
              state <= S_STPW;
            end
          end
          S_RUNW: begin
            if (done) state <= stop_pend ? S_STPW : S_MON;
            else if (skip) state <= S_STPW;
          end
          S_MON: begin
            if (stop) state <= S_STPW;
            else if (tmr_int) state <= S_RDISR;
          end
          S_RDISR: begin
            if (done) begin
              isr_val  <= rd_data;
              isr_vld  <= 1'b1;
              mask     <= DATA_W'(lowest_set(32'(rd_data)));
              hold_cnt <= 1'b0;
              if (stop_pend) state <= S_STPW;
              else if (rd_data == '0) state <= S_HOLD;
              else state <= S_CLR;
            end else if (skip) begin
              state <= S_STPW;
            end
          end
          S_CLR: begin
            if (done) begin
              hold_cnt <= 1'b0;
              state    <= stop_pend ? S_STPW : S_HOLD;
            end else if (skip) begin
              state <= S_STPW;
            end
          end
          S_HOLD: begin
            if (stop_pend) state <= S_STPW;
            else if (hold_cnt) state <= S_MON;
            else hold_cnt <= 1'b1;
          end
          S_STPW: begin
            if (done) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef TMR_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (to_err) err <= 1'b1;
    else if (state == S_IDLE && start) err <= 1'b0;
  end
`else
  assign err = 1'b0;
`endif

  tmr_bus_mst #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef TMR_SEQ_TIMEOUT_EN
    ,
    .TO_W(TO_W)
`endif
  ) u_bus (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .go_we    (go_we),
    .go_addr  (go_addr),
    .go_wdata (go_wdata),
    .done     (done),
    .to_err   (to_err),
    .rd_data  (rd_data),
    .req      (req),
    .we       (we),
    .be       (be),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .bus_rdata(rdata)
  );

endmodule

// File: tb/tb_tmr_cfg_seq.sv
// Scoreboard bench for tmr_cfg_seq: config load, IRQ service, stop, timeout.
// Timeout section is built only when TMR_SEQ_TIMEOUT_EN is defined.
module tb_tmr_cfg_seq;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          tmr_int = 1'b0;
  logic          gnt = 1'b0;
  logic          rvalid = 1'b0;
  logic [31:0]   rdata = 32'h0;
  logic [IW-1:0] tbl_idx;
  logic [31:0]   tbl_addr;
  logic [31:0]   tbl_wdata;
  logic          tbl_last;
  logic          req;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          busy;
  logic          running;
  logic          isr_vld;
  logic [31:0]   isr_val;
  logic          err;

  int checks = 0;
  int failures = 0;

  logic [31:0] t_addr [16];
  logic [31:0] t_data [16];
  int          t_len = 3;

  assign tbl_addr  = t_addr[tbl_idx];
  assign tbl_wdata = t_data[tbl_idx];
  assign tbl_last  = (int'(tbl_idx) == t_len - 1);

  always #5 clk = ~clk;

  tmr_cfg_seq #(
    .ADDR_W(32),
    .DATA_W(32),
    .IDX_W (IW)
`ifdef TMR_SEQ_TIMEOUT_EN
    ,
    .TO_W(4)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .tbl_idx  (tbl_idx),
    .tbl_addr (tbl_addr),
    .tbl_wdata(tbl_wdata),
    .tbl_last (tbl_last),
    .tmr_int  (tmr_int),
    .req      (req),
    .we       (we),
    .be       (be),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .busy     (busy),
    .running  (running),
    .isr_vld  (isr_vld),
    .isr_val  (isr_val),
    .err      (err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_q [$];
  logic [31:0] isr_q [$];
  xfer_t       e;
  logic [31:0] e_isr;

  logic [31:0] isr_data = 32'h0;
  logic [31:0] slow_addr = 32'hffff_ffff;
  bit          gnt_en = 1'b1;
  int          wcnt = 0;
  logic [31:0] h_addr;
  logic [31:0] h_wdata;
  bit          h_valid = 1'b0;
  int          n_req = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // slave: grant after a per-address delay, read data with the grant
  always @(negedge clk) begin
    gnt = 1'b0;
    rvalid = 1'b0;
    if (req && gnt_en) begin
      if (wcnt >= ((addr == slow_addr) ? 5 : 1)) begin
        gnt = 1'b1;
        wcnt = 0;
        if (!we) begin
          rvalid = 1'b1;
          rdata = isr_data;
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // monitor: pop the scoreboard on each accepted transfer / isr report
  always begin
    @(negedge clk);
    #2;
    if (req) begin
      if (h_valid) begin
        chk("hold_addr", addr, h_addr);
        chk("hold_wdata", wdata, h_wdata);
      end
      h_valid = !gnt;
      h_addr  = addr;
      h_wdata = wdata;
    end else begin
      h_valid = 1'b0;
    end
    if (req && gnt) begin
      chk("be", 32'(be), 32'hf);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_xfer: got we=%0b addr=%h wdata=%h expected none",
                 we, addr, wdata);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_we", 32'(we), 32'(e.we));
        chk("xfer_addr", addr, e.addr);
        chk("xfer_wdata", wdata, e.data);
      end
    end
    if (isr_vld) begin
      if (isr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_isr: got %h expected none", isr_val);
      end else begin
        e_isr = isr_q.pop_front();
        chk("isr_val", isr_val, e_isr);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic push_x(input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    exp_q.push_back(xfer_t'{w, a, d});
  endtask

  task automatic push_cfg();
    push_x(1'b1, 32'h04, 32'hff);
    push_x(1'b1, 32'h08, 32'hff);
    push_x(1'b1, 32'h0c, 32'h50);
    push_x(1'b1, 32'h10, 32'h1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300 && busy; i++) step();
    chk(name, 32'(busy), 32'h0);
  endtask

  task automatic wait_running(input string name);
    for (int i = 0; i < 300 && !running; i++) step();
    chk(name, 32'(running), 32'h1);
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 300 && (exp_q.size() + isr_q.size()) != 0; i++)
      step();
    chk(name, 32'(exp_q.size() + isr_q.size()), 32'h0);
  endtask

  task automatic irq(input logic [31:0] isr, input bit clr,
                     input logic [31:0] m);
    isr_data = isr;
    push_x(1'b0, 32'h14, 32'h0);
    if (clr) push_x(1'b1, 32'h18, m);
    isr_q.push_back(isr);
    tmr_int = 1'b1;
    step();
    chk("irq_latency_req", 32'(req), 32'h1);
    chk("irq_latency_addr", addr, 32'h14);
    wait_drained("irq_drained");
    tmr_int = 1'b0;
    repeat (5) step();
    chk("irq_back_running", 32'(running), 32'h1);
    chk("irq_back_req", 32'(req), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      t_addr[i] = 32'h0;
      t_data[i] = 32'h0;
    end
    t_addr[0] = 32'h04; t_data[0] = 32'hff;
    t_addr[1] = 32'h08; t_data[1] = 32'hff;
    t_addr[2] = 32'h0c; t_data[2] = 32'h50;

    repeat (3) step();
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_isr_vld", 32'(isr_vld), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_tbl_idx", 32'(tbl_idx), 32'h0);
    chk("rst_addr", addr, 32'h0);
    rst = 1'b0;
    step();

`ifdef TMR_SEQ_TIMEOUT_EN
    gnt_en = 1'b0;
    pulse_start();
    for (int i = 0; i < 60 && !err; i++) begin
      if (req) n_req++;
      step();
    end
    chk("to_req_cycles", 32'(n_req), 32'd15);
    chk("to_err", 32'(err), 32'h1);
    chk("to_busy", 32'(busy), 32'h0);
    chk("to_req", 32'(req), 32'h0);
    gnt_en = 1'b1;
    push_cfg();
    pulse_start();
    chk("to_err_cleared", 32'(err), 32'h0);
    wait_running("to_restart_running");
    wait_drained("to_restart_drained");
    push_x(1'b1, 32'h10, 32'h2);
    pulse_stop();
    wait_idle("to_stop_idle");
    wait_drained("to_stop_drained");
`endif

    // config load, entry 1 granted slowly
    slow_addr = 32'h08;
    push_cfg();
    pulse_start();
    wait_running("cfg_running");
    wait_drained("cfg_drained");
    chk("cfg_tbl_idx", 32'(tbl_idx), 32'h2);
    chk("cfg_busy", 32'(busy), 32'h1);
    repeat (3) step();

    irq(32'h50, 1'b1, 32'h10);
    irq(32'h40, 1'b1, 32'h40);
    irq(32'h0, 1'b0, 32'h0);

    // stop from MON
    push_x(1'b1, 32'h10, 32'h2);
    pulse_stop();
    wait_idle("mon_stop_idle");
    wait_drained("mon_stop_drained");
    chk("mon_stop_running", 32'(running), 32'h0);

    // stop while entry 1 is waiting for its grant
    push_x(1'b1, 32'h04, 32'hff);
    push_x(1'b1, 32'h08, 32'hff);
    push_x(1'b1, 32'h10, 32'h2);
    pulse_start();
    for (int i = 0; i < 100 && !(req && addr == 32'h08); i++) step();
    chk("cfg_stop_reach", addr, 32'h08);
    pulse_stop();
    wait_idle("cfg_stop_idle");
    wait_drained("cfg_stop_drained");
    chk("cfg_stop_idx", 32'(tbl_idx), 32'h1);

    // stop in IDLE is ignored
    pulse_stop();
    repeat (3) step();
    chk("idle_stop_busy", 32'(busy), 32'h0);
    chk("idle_stop_req", 32'(req), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
